// File: rtl/dht11_pkg.sv
// -----------------------------------------------------------------------------
// dht11_pkg
// Shared definitions for the DHT11 single-wire controller:
//   - dht11_state_e : protocol state enumeration
//   - timing constants in microseconds and the frame length in bits
//   - int_to_bcd    : integer byte -> two BCD digits, saturating at 99
//   - dec_to_digit  : decimal byte -> single digit, saturating at 9
// -----------------------------------------------------------------------------
package dht11_pkg;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      START_LOW = 4'd1,
      START_REL = 4'd2,
      RESP_WAIT = 4'd3,
      RESP_LOW  = 4'd4,
      RESP_HIGH = 4'd5,
      BIT_LOW   = 4'd6,
      BIT_HIGH  = 4'd7,
      FINISH    = 4'd8
   } dht11_state_e;

   // Host start pulse, release gap, and the 0/1 decision threshold (us)
   localparam int unsigned T_START_LOW_US = 18000;
   localparam int unsigned T_START_REL_US = 30;
   localparam int unsigned T_BIT_ONE_US   = 40;
   localparam int unsigned FRAME_BITS     = 40;

   // Split a byte into tens/ones BCD digits; anything above 99 reads as 99
   function automatic logic [7:0] int_to_bcd(input logic [7:0] v);
      logic [7:0] r;
      if (v > 8'd99) begin
         r = 8'h99;
      end else begin
         r = {4'(v / 8'd10), 4'(v % 8'd10)};
      end
      return r;
   endfunction

   // Fractional part is shown as one digit, clipped at 9
   function automatic logic [3:0] dec_to_digit(input logic [7:0] v);
      logic [3:0] r;
      if (v > 8'd9) begin
         r = 4'd9;
      end else begin
         r = v[3:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/dht11_tick_gen.sv
// -----------------------------------------------------------------------------
// dht11_tick_gen
// Produces a one-clock pulse every microsecond of clk.
// Parameters: CLK_HZ - clk frequency in Hz (values below 1 MHz tick every cycle)
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   tick_o out one-cycle pulse once per microsecond
// -----------------------------------------------------------------------------
module dht11_tick_gen #(
   parameter int unsigned CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick_o
);

   localparam int unsigned DIV  = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
   localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic          tick_q;

   // Free-running divider; the tick is registered on wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else if (cnt_q == LAST) begin
         cnt_q  <= '0;
         tick_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_q + CW'(1);
         tick_q <= 1'b0;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/dht11_ctrl.sv
// -----------------------------------------------------------------------------
// dht11_ctrl
// Runs one DHT11 measurement per start pulse: host start pulse, sensor
// response handshake, 40-bit frame capture, conversion to BCD digits.
// Parameters:
//   CLK_HZ       clk frequency in Hz
//   TIMEOUT_US   longest allowed wait on any sensor-driven line level
//   START_LOW_US length of the host start pulse (sensor needs >= 18 ms)
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle measurement request (ignored while busy)
//   dht_io              open-drain data line, driven 0 or released
//   humi10/humi0/humi_minority, temp10/temp0/temp_minority
//                       BCD digits of the last valid frame
//   o_error             1 when the last measurement failed
//   o_busy              high while a measurement is in progress
//   o_done              one-cycle pulse at the end of each measurement
// Build option: define DHT11_CHECKSUM_EN to reject frames whose byte4 does
// not equal the modulo-256 sum of bytes 0..3.
// -----------------------------------------------------------------------------
module dht11_ctrl
   import dht11_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned TIMEOUT_US   = 200,
   parameter int unsigned START_LOW_US = T_START_LOW_US
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   inout  wire        dht_io,
   output logic [3:0] humi10,
   output logic [3:0] humi0,
   output logic [3:0] humi_minority,
   output logic [3:0] temp10,
   output logic [3:0] temp0,
   output logic [3:0] temp_minority,
   output logic       o_error,
   output logic       o_busy,
   output logic       o_done
);

   localparam logic [15:0] LOW_LIM = 16'(START_LOW_US - 1);
   localparam logic [15:0] REL_LIM = 16'(T_START_REL_US - 1);
   localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_US - 1);
   localparam logic [15:0] ONE_THR = 16'(T_BIT_ONE_US);
   localparam logic [5:0]  LAST_BIT = 6'(FRAME_BITS - 1);

   dht11_state_e state_q;
   logic [15:0]  timer_q;
   logic [5:0]   bit_cnt_q;
   logic [39:0]  shift_q;
   logic         drive_low_q;
   logic         fail_q;
   logic         line_meta_q;
   logic         line_q;
   logic         tick_s;
   logic         tmo_s;
   logic         frame_bad_s;
   logic [7:0]   humi_bcd_s;
   logic [7:0]   temp_bcd_s;

   dht11_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .tick_o (tick_s)
   );

   // Open-drain: only ever pull low, the external pull-up provides the high
   assign dht_io = drive_low_q ? 1'b0 : 1'bz;

   // Two-stage synchronizer; idle line level is high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_meta_q <= 1'b1;
         line_q      <= 1'b1;
      end else begin
         line_meta_q <= dht_io;
         line_q      <= line_meta_q;
      end
   end

   // A sensor wait has used up its budget on this tick
   assign tmo_s = tick_s && (timer_q == TMO_LIM);

   // Frame conversion and integrity check
   always_comb begin
      humi_bcd_s = int_to_bcd(shift_q[39:32]);
      temp_bcd_s = int_to_bcd(shift_q[23:16]);
`ifdef DHT11_CHECKSUM_EN
      frame_bad_s = (shift_q[7:0] != 8'(shift_q[39:32] + shift_q[31:24]
                                      + shift_q[23:16] + shift_q[15:8]));
`else
      frame_bad_s = 1'b0;
`endif
   end

   // Protocol FSM with registered outputs; timer_q counts microseconds in
   // the current state and doubles as the bit high-time measurement
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         drive_low_q   <= 1'b0;
         fail_q        <= 1'b0;
         humi10        <= 4'd0;
         humi0         <= 4'd0;
         humi_minority <= 4'd0;
         temp10        <= 4'd0;
         temp0         <= 4'd0;
         temp_minority <= 4'd0;
         o_error       <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (tick_s) begin
            timer_q <= timer_q + 16'd1;
         end
         case (state_q)
            IDLE: begin
               drive_low_q <= 1'b0;
               o_busy      <= 1'b0;
               timer_q     <= '0;
               if (start) begin
                  state_q     <= START_LOW;
                  drive_low_q <= 1'b1;
                  o_busy      <= 1'b1;
                  bit_cnt_q   <= '0;
                  shift_q     <= '0;
                  fail_q      <= 1'b0;
               end
            end
            START_LOW: begin
               if (tick_s && timer_q == LOW_LIM) begin
                  state_q     <= START_REL;
                  drive_low_q <= 1'b0;
                  timer_q     <= '0;
               end
            end
            START_REL: begin
               if (tick_s && timer_q == REL_LIM) begin
                  state_q <= RESP_WAIT;
                  timer_q <= '0;
               end
            end
            RESP_WAIT: begin
               if (!line_q) begin
                  state_q <= RESP_LOW;
                  timer_q <= '0;
               end else if (tmo_s) begin
                  state_q <= FINISH;
                  fail_q  <= 1'b1;
               end
            end
            RESP_LOW: begin
               if (line_q) begin
                  state_q <= RESP_HIGH;
                  timer_q <= '0;
               end else if (tmo_s) begin
                  state_q <= FINISH;
                  fail_q  <= 1'b1;
               end
            end
            RESP_HIGH: begin
               if (!line_q) begin
                  state_q <= BIT_LOW;
                  timer_q <= '0;
               end else if (tmo_s) begin
                  state_q <= FINISH;
                  fail_q  <= 1'b1;
               end
            end
            BIT_LOW: begin
               if (line_q) begin
                  state_q <= BIT_HIGH;
                  timer_q <= '0;
               end else if (tmo_s) begin
                  state_q <= FINISH;
                  fail_q  <= 1'b1;
               end
            end
            BIT_HIGH: begin
               if (!line_q) begin
                  // Long high pulse encodes a 1
                  shift_q <= {shift_q[38:0], (timer_q > ONE_THR)};
                  timer_q <= '0;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_q <= FINISH;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 6'd1;
                     state_q   <= BIT_LOW;
                  end
               end else if (tmo_s) begin
                  state_q <= FINISH;
                  fail_q  <= 1'b1;
               end
            end
            FINISH: begin
               if (fail_q || frame_bad_s) begin
                  o_error <= 1'b1;
               end else begin
                  humi10        <= humi_bcd_s[7:4];
                  humi0         <= humi_bcd_s[3:0];
                  humi_minority <= dec_to_digit(shift_q[31:24]);
                  temp10        <= temp_bcd_s[7:4];
                  temp0         <= temp_bcd_s[3:0];
                  temp_minority <= dec_to_digit(shift_q[15:8]);
                  o_error       <= 1'b0;
               end
               o_done  <= 1'b1;
               o_busy  <= 1'b0;
               timer_q <= '0;
               state_q <= IDLE;
            end
            default: begin
               state_q     <= IDLE;
               drive_low_q <= 1'b0;
               o_busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dht11_ctrl.sv
`timescale 1ns/1ps
module tb_dht11_ctrl;

   localparam int HALF_NS = 250;              // 2 MHz clock, 2 cycles per us

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic sens_low;
   wire  dht_io;
   logic [3:0] humi10, humi0, humi_minority, temp10, temp0, temp_minority;
   logic o_error, o_busy, o_done;

   int n_assert = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int d0;
   int lc;
   int cyc;

   pullup (dht_io);
   assign dht_io = sens_low ? 1'b0 : 1'bz;

   always #(HALF_NS) clk = ~clk;

   dht11_ctrl #(
      .CLK_HZ       (2_000_000),
      .TIMEOUT_US   (200),
      .START_LOW_US (400)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .dht_io        (dht_io),
      .humi10        (humi10),
      .humi0         (humi0),
      .humi_minority (humi_minority),
      .temp10        (temp10),
      .temp0         (temp0),
      .temp_minority (temp_minority),
      .o_error       (o_error),
      .o_busy        (o_busy),
      .o_done        (o_done)
   );

   wire [23:0] digits_s = {humi10, humi0, humi_minority, temp10, temp0, temp_minority};

   always @(negedge clk) begin
      if (o_done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int v, input int lo, input int hi);
      n_assert++;
      assert (v >= lo && v <= hi) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
      end
   endtask

   task automatic us(input int n);
      #(n * 1000);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_line(input logic lvl, input int budget, input string tag, output int c);
      c = 0;
      while (dht_io !== lvl && c < budget) begin
         @(negedge clk);
         c++;
      end
      check(tag, 32'(c < budget), 32'd1);
   endtask

   task automatic wait_done(input int budget, input string tag, output int c);
      c = 0;
      while (o_done !== 1'b1 && c < budget) begin
         @(negedge clk);
         c++;
      end
      check(tag, 32'(c < budget), 32'd1);
   endtask

   // Start request, then time the host low pulse until the line is released
   task automatic host_phase(output int low_cyc);
      int c;
      pulse_start();
      wait_line(1'b0, 20, "start_drive", c);
      wait_line(1'b1, 2000, "start_release", low_cyc);
   endtask

   // Sensor side: response handshake and 40 bits MSB first
   task automatic sensor_frame(input logic [39:0] frame, input int extra_bit, input int abort_bit);
      us(35); sens_low = 1'b1; us(80); sens_low = 1'b0; us(80);
      for (int i = 0; i < 40; i++) begin
         sens_low = 1'b1;
         if (i == abort_bit) begin
            us(10); rst = 1'b1; sens_low = 1'b0;
            break;
         end
         if (i == extra_bit) begin
            us(10); pulse_start(); us(38);
         end else begin
            us(50);
         end
         sens_low = 1'b0;
         if (frame[39 - i]) us(70); else us(26);
      end
      if (abort_bit < 0) sens_low = 1'b1;
   endtask

   task automatic end_frame(input string tag);
      int c;
      wait_done(40, tag, c);
      us(50); sens_low = 1'b0; us(20);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sens_low = 1'b0;
      repeat (6) @(negedge clk);
      check("rst_digits", digits_s, 24'h0);
      check("rst_error", o_error, 1'b0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_done", o_done, 1'b0);
      check("rst_line", dht_io, 1'b1);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      // 45,0,23,7,75 with an extra start during bit 5 low phase
      d0 = done_cnt;
      host_phase(lc);
      check_range("start_low_width", lc, 796, 804);
      check("busy_in_frame", o_busy, 1'b1);
      sensor_frame(40'h2D_00_17_07_4B, 5, -1);
      end_frame("frame_a_done");
      check("frame_a_digits", digits_s, 24'h450237);
      check("frame_a_error", o_error, 1'b0);
      check("frame_a_done_count", 32'(done_cnt - d0), 32'd1);
      check("frame_a_no_restart", dht_io, 1'b1);
      check("frame_a_busy_clr", o_busy, 1'b0);

      // 120,12,5,3,140 saturates
      d0 = done_cnt;
      host_phase(lc);
      sensor_frame(40'h78_0C_05_03_8C, -1, -1);
      end_frame("frame_b_done");
      check("frame_b_digits", digits_s, 24'h999053);
      check("frame_b_error", o_error, 1'b0);
      check("frame_b_done_count", 32'(done_cnt - d0), 32'd1);

`ifdef DHT11_CHECKSUM_EN
      // Bad checksum keeps the previous digits
      host_phase(lc);
      sensor_frame(40'h2D_00_17_07_4C, -1, -1);
      end_frame("frame_c_done");
      check("cks_error", o_error, 1'b1);
      check("cks_digits_hold", digits_s, 24'h999053);
`endif

      // No response: release + 30 us + 200 us
      d0 = done_cnt;
      host_phase(lc);
      wait_done(600, "timeout_done", cyc);
      check_range("timeout_latency", cyc, 455, 467);
      repeat (2) @(negedge clk);
      check("timeout_error", o_error, 1'b1);
      check("timeout_digits_hold", digits_s, 24'h999053);
      check("timeout_done_count", 32'(done_cnt - d0), 32'd1);
      repeat (100) @(negedge clk);
      check("error_holds", o_error, 1'b1);

      // Reset at bit 20
      d0 = done_cnt;
      host_phase(lc);
      sensor_frame(40'h2D_00_17_07_4B, -1, 20);
      repeat (4) @(negedge clk);
      check("abort_line", dht_io, 1'b1);
      check("abort_digits", digits_s, 24'h0);
      check("abort_error", o_error, 1'b0);
      check("abort_busy", o_busy, 1'b0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);

      // Normal measurement after the reset
      d0 = done_cnt;
      host_phase(lc);
      sensor_frame(40'h2D_00_17_07_4B, -1, -1);
      end_frame("frame_d_done");
      check("frame_d_digits", digits_s, 24'h450237);
      check("frame_d_error", o_error, 1'b0);
      check("frame_d_done_count", 32'(done_cnt - d0), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dht11_ctrl.md
DHT11_CTRL -- requirements
Module: dht11_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_US, default 200, maximum microseconds any single line-level wait may last.
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse requesting one measurement.
REQ-006 SHALL have port dht_io  inout  1  DHT11 single-wire data; driven 0 or high-Z only.
REQ-007 SHALL have ports humi10, humi0, humi_minority, temp10, temp0, temp_minority  output  4 each  BCD digits of the last valid frame.
REQ-008 SHALL have port o_error  output  1  result of the last measurement: 1 = failed, 0 = valid.
REQ-009 SHALL have port o_busy  output  1  high from the accepted start until the measurement ends.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse at the end of every measurement, pass or fail.

Function
REQ-011 SHALL derive a 1 us tick from clk; all protocol timing SHALL count in these ticks.
REQ-012 SHALL sample dht_io through a 2-FF synchronizer before any decision.
REQ-013 SHALL implement the states IDLE, START_LOW, START_REL, RESP_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH and FINISH.
REQ-014 IDLE: line released, o_busy=0. start -> START_LOW; start while o_busy=1 SHALL be ignored.
REQ-015 START_LOW: drive dht_io=0 for 18000 us, then go to START_REL.
REQ-016 START_REL: release the line for 30 us, then go to RESP_WAIT.
REQ-017 RESP_WAIT: on line low, go to RESP_LOW.
REQ-018 RESP_LOW: on line high, go to RESP_HIGH.
REQ-019 RESP_HIGH: on line low, go to BIT_LOW.
REQ-020 BIT_LOW: on line high, go to BIT_HIGH and clear the high-time counter.
REQ-021 BIT_HIGH: on line low, shift in bit = (high time > 40 us), MSB first; after bit 40 go to FINISH, else go to BIT_LOW.
REQ-022 In RESP_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW and BIT_HIGH, a wait exceeding TIMEOUT_US SHALL go to FINISH with error.
REQ-023 The frame is 40 bits: byte0 humidity integer, byte1 humidity decimal, byte2 temperature integer, byte3 temperature decimal, byte4 checksum.
REQ-024 FINISH on a valid frame: update all six digits in the same cycle, o_error=0, o_done=1 for one cycle, then go to IDLE.
REQ-025 Integer bytes SHALL convert as tens = value/10 and ones = value%10; values >99 SHALL saturate to 9,9.
REQ-026 Decimal bytes SHALL map to the minority digit as min(value,9).
REQ-027 FINISH on error: o_error=1, digits hold their previous values, o_done=1 for one cycle, then go to IDLE.
REQ-028 o_error SHALL hold until the next FINISH.

Reset
REQ-029 Reset SHALL force IDLE, release dht_io, and zero all digits, o_error, o_busy, o_done, the bit counter and the shift register.
REQ-030 Reset mid-frame SHALL discard the partial frame; no o_done pulse is generated.

Configuration
REQ-031 With DHT11_CHECKSUM_EN defined, FINISH SHALL flag error when byte4 != (byte0+byte1+byte2+byte3) mod 256.
REQ-032 Without DHT11_CHECKSUM_EN, byte4 SHALL be ignored and only timeouts produce errors.

Structure
REQ-033 Package dht11_pkg SHALL hold the state enumeration and the timing constants (18000, 30, 40, frame length 40).
REQ-034 The 1 us tick generator SHALL be sub-module dht11_tick_gen, parameterized by CLK_HZ.

Verification
REQ-035 Sensor model sends 45,0,23,7,75 -> digits 4,5,0,2,3,7; o_error=0; one o_done pulse.
REQ-036 With DHT11_CHECKSUM_EN, frame 45,0,23,7,76 -> o_error=1, digits unchanged from the prior valid frame.
REQ-037 No sensor response after start -> FINISH 200 us after RESP_WAIT entry; o_error=1.
REQ-038 Frame 120,12,5,3,140 -> humi 9,9,9 and temp 0,5,3.
REQ-039 Second start pulse during BIT_LOW -> ignored; exactly one o_done pulse.
REQ-040 rst asserted at bit 20 -> dht_io high-Z, outputs zero, no o_done; a following start completes normally.
